// File: rtl/pipe_hazard_pkg.sv
// rtl/pipe_hazard_pkg.sv - shared types and stage constants for the pipeline hazard controller
package pipe_hazard_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DFLUSH  = 2'd1,
        IFLUSH  = 2'd2,
        REFETCH = 2'd3
    } fence_state_t;

    localparam int IF_IDX     = 0;
    localparam int DEF_NSTAGE = 5;
    localparam int DEF_EX_IDX = 2;

endpackage

// File: rtl/pipe_fence_fsm.sv
// rtl/pipe_fence_fsm.sv - fence.i sequencer: data-cache flush, instruction-cache flush, refetch
module pipe_fence_fsm
    import pipe_hazard_pkg::*;
(
    input  logic CLK,
    input  logic nRST,
    input  logic start,
    input  logic abort,
    input  logic dflush_done,
    input  logic iflush_done,
    output logic dflush_req,
    output logic iflush_req,
    output logic busy,
    output logic refetch
);

    fence_state_t r_state;
    fence_state_t w_next;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Moore outputs: an abort takes effect on the state, so requests drop the following cycle
    always_comb begin
        w_next     = r_state;
        dflush_req = 1'b0;
        iflush_req = 1'b0;
        busy       = 1'b0;
        refetch    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_next = DFLUSH;
            end
            DFLUSH: begin
                dflush_req = 1'b1;
                busy       = 1'b1;
                if (dflush_done) w_next = IFLUSH;
            end
            IFLUSH: begin
                iflush_req = 1'b1;
                busy       = 1'b1;
                if (iflush_done) w_next = REFETCH;
            end
            REFETCH: begin
                refetch = 1'b1;
                w_next  = IDLE;
            end
            default: w_next = IDLE;
        endcase
        if (abort) w_next = IDLE;
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - per-stage stall/flush, PC select and trap hand-off for an NSTAGE pipeline
module pipe_hazard_ctrl
    import pipe_hazard_pkg::*;
#(
    parameter int NSTAGE   = DEF_NSTAGE,
    parameter int EX_IDX   = DEF_EX_IDX,
    parameter int LOAD_LAT = 1,
    parameter int REG_W    = 5
) (
    input  logic                      CLK,
    input  logic                      nRST,
    input  logic [REG_W-1:0]          id_rs1,
    input  logic [REG_W-1:0]          id_rs2,
    input  logic                      id_rs1_used,
    input  logic                      id_rs2_used,
    input  logic [REG_W-1:0]          ex_rd,
    input  logic                      ex_load,
    input  logic                      stall_ex,
    input  logic                      imem_busy,
    input  logic                      dmem_busy,
    input  logic                      dmem_access,
    input  logic                      redirect,
    input  logic                      csr,
    input  logic                      ifence,
    input  logic                      dflush_done,
    input  logic                      iflush_done,
    input  logic [NSTAGE-1:0]         exc_valid,
    input  logic                      intr_req,
    input  logic                      ret,
    output logic                      pc_en,
    output logic [NSTAGE-1:0]         stall,
    output logic [NSTAGE-1:0]         flush,
    output logic                      npc_sel,
    output logic                      dflush_req,
    output logic                      iflush_req,
    output logic                      fence_refetch,
    output logic [$clog2(NSTAGE)-1:0] exc_stage,
    output logic                      pipe_clear,
    output logic                      intr_taken
);

    localparam int                SW       = $clog2(NSTAGE);
    localparam logic [NSTAGE-1:0] ALL_ONES = {NSTAGE{1'b1}};
    localparam logic [NSTAGE-1:0] MASK_EX  = ALL_ONES >> (NSTAGE - 1 - EX_IDX);
    localparam logic [NSTAGE-1:0] MASK_PRE = ALL_ONES >> (NSTAGE - EX_IDX);
    localparam logic [NSTAGE-1:0] BIT_DEC  = NSTAGE'(1) << (EX_IDX - 1);
    localparam logic [NSTAGE-1:0] BIT_EX   = NSTAGE'(1) << EX_IDX;

    logic          r_intr_pend;
    logic [2:0]    r_lu_cnt;
    logic [SW-1:0] w_k;
    logic          w_exc_any;
    logic          w_exc_late;
    logic          w_intr_take;
    logic          w_lu_hazard;
    logic          w_lu_active;
    logic          w_lu_clear;
    logic          w_lu_hold;
    logic          w_fence_start;
    logic          w_fence_busy;
    logic          w_fence_idle;

    assign w_exc_any  = |exc_valid;
    assign w_exc_late = |(exc_valid & ~MASK_EX);

    always_comb begin
        w_k = '0;
        for (int i = 0; i < NSTAGE; i++) begin
            if (exc_valid[i]) w_k = SW'(i);
        end
    end

    assign w_lu_hazard = ex_load && (ex_rd != '0) &&
                         ((id_rs1_used && (id_rs1 == ex_rd)) ||
                          (id_rs2_used && (id_rs2 == ex_rd)));
    assign w_lu_active = w_lu_hazard || (r_lu_cnt != 3'd0);

    assign w_fence_idle  = !w_fence_busy && !fence_refetch;
    assign w_intr_take   = r_intr_pend && !w_exc_any && w_fence_idle && !dmem_busy;
    assign w_fence_start = ifence && !stall_ex && !w_exc_any && !w_intr_take && !ret;

    pipe_fence_fsm u_fence (
        .CLK         (CLK),
        .nRST        (nRST),
        .start       (w_fence_start),
        .abort       (w_exc_late),
        .dflush_done (dflush_done),
        .iflush_done (iflush_done),
        .dflush_req  (dflush_req),
        .iflush_req  (iflush_req),
        .busy        (w_fence_busy),
        .refetch     (fence_refetch)
    );

    // One priority chain; lower causes are masked entirely by a higher one
    always_comb begin
        stall      = '0;
        flush      = '0;
        npc_sel    = 1'b0;
        pipe_clear = 1'b0;
        intr_taken = 1'b0;
        w_lu_clear = 1'b0;
        w_lu_hold  = 1'b0;
        if (w_exc_any) begin
            pipe_clear = 1'b1;
            flush      = ALL_ONES >> (NSTAGE - 1 - int'(w_k));
            w_lu_clear = 1'b1;
        end else if (w_intr_take) begin
            pipe_clear = 1'b1;
            intr_taken = 1'b1;
            flush      = ALL_ONES;
            w_lu_clear = 1'b1;
        end else if (ret) begin
            flush      = MASK_EX;
            w_lu_clear = 1'b1;
        end else if (w_fence_busy) begin
            stall     = MASK_EX;
            w_lu_hold = 1'b1;
        end else if (fence_refetch) begin
            flush      = MASK_EX;
            w_lu_clear = 1'b1;
        end else if (stall_ex) begin
            stall     = MASK_EX;
            flush     = BIT_EX;
            w_lu_hold = 1'b1;
        end else if (redirect) begin
            flush      = MASK_EX;
            npc_sel    = 1'b1;
            w_lu_clear = 1'b1;
        end else if (csr) begin
            flush      = MASK_EX;
            w_lu_clear = 1'b1;
        end else if (w_lu_active) begin
            stall = MASK_PRE;
            flush = BIT_DEC;
        end
    end

    assign exc_stage = w_k;
    assign pc_en     = !(imem_busy || (dmem_access && dmem_busy) || stall[IF_IDX]) ||
                       pipe_clear || npc_sel || fence_refetch;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_lu_cnt    <= 3'd0;
            r_intr_pend <= 1'b0;
        end else begin
            if (w_lu_clear) begin
                r_lu_cnt <= 3'd0;
            end else if (w_lu_hold) begin
                r_lu_cnt <= r_lu_cnt;
            end else if (r_lu_cnt != 3'd0) begin
                r_lu_cnt <= r_lu_cnt - 3'd1;
            end else if (w_lu_hazard) begin
                r_lu_cnt <= 3'(LOAD_LAT - 1);
            end
            if (w_intr_take) begin
                r_intr_pend <= 1'b0;
            end else begin
                r_intr_pend <= intr_req;
            end
        end
    end

endmodule
